mem_arbiter_rr: RTL

- Parametrised N-port memory arbiter with round-robin grant; successor to the fixed 2-port instruction/data arbiter.
- Sits between NUM_PORTS cache miss ports (I-cache, D-cache, later L2/prefetch) and the single cacheline adapter port.
- Serialises full-line read and write transactions with a registered response and a turnaround cycle.

---
 rtl/mem_arbiter_rr.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter_rr.sv
// N-port cacheline memory arbiter: round-robin grant, serialised read/write, registered response + turnaround.
// Define ARB_FIXED_PRIORITY_EN to replace round-robin with strict lowest-index priority.
module mem_arbiter_rr #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             req_resp,
  output logic [LINE_WIDTH-1:0]            req_rdata,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [LINE_WIDTH-1:0]            mem_wdata,
  input  logic [LINE_WIDTH-1:0]            mem_rdata,
  input  logic                             mem_resp
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        gnt_q, gnt_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
  logic [LINE_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [NUM_PORTS-1:0]    req_resp_q, req_resp_d;
  logic [LINE_WIDTH-1:0]   req_rdata_q, req_rdata_d;

  logic [NUM_PORTS-1:0]    active_c;
  logic                    any_active_c;
  logic [PTR_W-1:0]        base_c;
  logic [PTR_W-1:0]        sel_c;
  logic [ADDR_WIDTH-1:0]   addr_arr [NUM_PORTS];
  logic [LINE_WIDTH-1:0]   wdata_arr [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = req_wdata[i*LINE_WIDTH +: LINE_WIDTH];
  end

  assign active_c     = req_read | req_write;
  assign any_active_c = |active_c;

  // First active port at or above base, wrapping modulo NUM_PORTS.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] act,
                                               input logic [PTR_W-1:0]     base);
    logic [PTR_W-1:0] pick;
    logic             found;
    int unsigned      idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = 32'(base) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && act[PTR_W'(idx)]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
    return pick;
  endfunction

  assign sel_c = rr_pick(active_c, base_c);

`ifdef ARB_FIXED_PRIORITY_EN
  assign base_c = '0;
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;

  assign base_c = ptr_q;

  // Pointer advances past the winner only when a grant is made.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && any_active_c) begin
      if (32'(sel_c) == NUM_PORTS - 1) ptr_d = '0;
      else                             ptr_d = sel_c + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    req_resp_d    = '0;
    req_rdata_d   = req_rdata_q;
    case (state_q)
      IDLE: begin
        if (any_active_c) begin
          gnt_d         = sel_c;
          mem_write_d   = req_write[sel_c];
          mem_read_d    = !req_write[sel_c];
          mem_address_d = addr_arr[sel_c];
          mem_wdata_d   = wdata_arr[sel_c];
          state_d       = BUSY;
        end
      end
      BUSY: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) req_rdata_d = mem_rdata;
          req_resp_d[gnt_q] = 1'b1;
          state_d     = DONE;
        end
      end
      // Turnaround: no arbitration here so a port dropping its request is not re-granted.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      req_resp_q    <= '0;
      req_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      req_resp_q    <= req_resp_d;
      req_rdata_q   <= req_rdata_d;
    end
  end

  assign req_resp    = req_resp_q;
  assign req_rdata   = req_rdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;

endmodule
